// File: rtl/poly_writeback_demux.sv
// Write-back stage: narrows a full-width result polynomial and streams it, LANES
// coefficients per cycle, into one of four small-poly registers or the normal-poly register.
module poly_writeback_demux #(
  parameter int N           = 256,
  parameter int ARITH_WIDTH = 16,
  parameter int SPOLY_WIDTH = 3,
  parameter int R_WIDTH     = 12,
  parameter int LANES       = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [2:0]                 dest_i,
  input  logic [N*ARITH_WIDTH-1:0]   in_poly_i,
  output logic [N*SPOLY_WIDTH-1:0]   out0_o,
  output logic [N*SPOLY_WIDTH-1:0]   out1_o,
  output logic [N*SPOLY_WIDTH-1:0]   out2_o,
  output logic [N*SPOLY_WIDTH-1:0]   out3_o,
  output logic [N*R_WIDTH-1:0]       out4_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       range_err_o,
  output logic                       dest_err_o
);

  localparam int BEATS   = N / LANES;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int S_MAX_I = 2 ** (SPOLY_WIDTH - 1) - 1;
  localparam int R_MAX_I = 2 ** R_WIDTH - 1;

  localparam logic signed [ARITH_WIDTH-1:0] S_MAX = ARITH_WIDTH'(S_MAX_I);
  localparam logic signed [ARITH_WIDTH-1:0] S_MIN = ARITH_WIDTH'(-S_MAX_I - 1);
  localparam logic signed [ARITH_WIDTH-1:0] R_MAX = ARITH_WIDTH'(R_MAX_I);
  localparam logic [BEAT_W-1:0]             LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [2:0]                    DEST_NORMAL = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [N*ARITH_WIDTH-1:0]  buf_q, buf_d;
  logic [2:0]                dest_q, dest_d;
  logic [N*SPOLY_WIDTH-1:0]  small_q [4];
  logic [N*SPOLY_WIDTH-1:0]  small_d [4];
  logic [N*R_WIDTH-1:0]      out4_q, out4_d;
  logic                      range_err_q, range_err_d;
  logic                      dest_err_q, dest_err_d;

  logic signed [ARITH_WIDTH-1:0] lane_c [LANES];
  logic [SPOLY_WIDTH-1:0]        lane_s [LANES];
  logic [R_WIDTH-1:0]            lane_r [LANES];
  logic [LANES-1:0]              sat_s;
  logic [LANES-1:0]              sat_r;
  logic                          accept;

  // The buffer shifts down one beat per write, so the current beat always sits in the low lanes.
  always_comb begin
    sat_s = '0;
    sat_r = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_c[k] = buf_q[k*ARITH_WIDTH +: ARITH_WIDTH];
      if (lane_c[k] < S_MIN) begin
        lane_s[k] = {1'b1, {(SPOLY_WIDTH-1){1'b0}}};
        sat_s[k]  = 1'b1;
      end else if (lane_c[k] > S_MAX) begin
        lane_s[k] = {1'b0, {(SPOLY_WIDTH-1){1'b1}}};
        sat_s[k]  = 1'b1;
      end else begin
        lane_s[k] = lane_c[k][SPOLY_WIDTH-1:0];
      end
      if (lane_c[k][ARITH_WIDTH-1]) begin
        lane_r[k] = '0;
        sat_r[k]  = 1'b1;
      end else if (lane_c[k] > R_MAX) begin
        lane_r[k] = '1;
        sat_r[k]  = 1'b1;
      end else begin
        lane_r[k] = lane_c[k][R_WIDTH-1:0];
      end
    end
  end

  assign in_ready_o  = (state_q == S_IDLE) && !rst_i;
  assign accept      = in_valid_i && in_ready_o;
  assign busy_o      = (state_q == S_WRITE);
  assign done_o      = (state_q == S_DONE);
  assign range_err_o = range_err_q;
  assign dest_err_o  = dest_err_q;
  assign out0_o      = small_q[0];
  assign out1_o      = small_q[1];
  assign out2_o      = small_q[2];
  assign out3_o      = small_q[3];
  assign out4_o      = out4_q;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    buf_d       = buf_q;
    dest_d      = dest_q;
    small_d     = small_q;
    out4_d      = out4_q;
    range_err_d = range_err_q;
    dest_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (dest_i <= DEST_NORMAL) begin
            buf_d       = in_poly_i;
            dest_d      = dest_i;
            range_err_d = 1'b0;
            beat_d      = '0;
            state_d     = S_WRITE;
          end else begin
            dest_err_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        buf_d  = buf_q >> (LANES * ARITH_WIDTH);
        beat_d = beat_q + 1'b1;
        if (dest_q == DEST_NORMAL) begin
          for (int k = 0; k < LANES; k++) begin
            out4_d[(int'(beat_q)*LANES + k)*R_WIDTH +: R_WIDTH] = lane_r[k];
          end
          if (|sat_r) range_err_d = 1'b1;
        end else begin
          for (int k = 0; k < LANES; k++) begin
            small_d[dest_q[1:0]][(int'(beat_q)*LANES + k)*SPOLY_WIDTH +: SPOLY_WIDTH] = lane_s[k];
          end
          if (|sat_s) range_err_d = 1'b1;
        end
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      buf_q   <= '0;
      dest_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        small_q[i] <= '0;
      end
      out4_q      <= '0;
      range_err_q <= 1'b0;
      dest_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      buf_q       <= buf_d;
      dest_q      <= dest_d;
      small_q     <= small_d;
      out4_q      <= out4_d;
      range_err_q <= range_err_d;
      dest_err_q  <= dest_err_d;
    end
  end

endmodule
